// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with synchronous Gray load, wrap or saturate at the limits.
// The Gray view comes straight from flops so other clock domains can sample it safely.
module gray_counter_ud #(
    parameter int DATA_WIDTH = 4,
    parameter bit WRAP       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_gray,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  tc,
    output logic                  ovf
);

    localparam logic [DATA_WIDTH-1:0] MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] bin_r, gray_r;
    logic                  ovf_r;
    logic [DATA_WIDTH-1:0] bin_nx, gray_nx;
    logic                  ovf_nx;
    logic                  at_limit;

    assign at_limit = up ? (bin_r == MAX) : (bin_r == ZERO);

    always_comb begin
        bin_nx  = bin_r;
        gray_nx = gray_r;
        ovf_nx  = 1'b0;
        if (load) begin
            bin_nx  = gray2bin(load_gray);
            gray_nx = load_gray;
        end else if (en) begin
            if (at_limit) begin
                ovf_nx = 1'b1;
                if (WRAP) begin
                    bin_nx = up ? ZERO : MAX;
                end
            end else begin
                bin_nx = up ? (bin_r + ONE) : (bin_r - ONE);
            end
            // Gray is derived from the next binary value so both registers move together.
            gray_nx = bin_nx ^ (bin_nx >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r  <= '0;
            gray_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            bin_r  <= bin_nx;
            gray_r <= gray_nx;
            ovf_r  <= ovf_nx;
        end
    end

    assign out     = gray_r;
    assign bin_out = bin_r;
    assign ovf     = ovf_r;
    assign tc      = up ? (bin_r == MAX) : (bin_r == ZERO);

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed and randomised checks for gray_counter_ud: 4-bit wrap, 4-bit saturate and 1-bit instances.
module tb_gray_counter_ud;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit wrapping instance
    logic       a_rst, a_en, a_up, a_ld, a_tc, a_ovf;
    logic [3:0] a_lg, a_out, a_bin;
    // 4-bit saturating instance
    logic       s_rst, s_en, s_up, s_ld, s_tc, s_ovf;
    logic [3:0] s_lg, s_out, s_bin;
    // 1-bit wrapping instance
    logic       o_rst, o_en, o_up, o_ld, o_tc, o_ovf;
    logic [0:0] o_lg, o_out, o_bin;

    gray_counter_ud #(.DATA_WIDTH(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(a_rst), .en(a_en), .up(a_up), .load(a_ld), .load_gray(a_lg),
        .out(a_out), .bin_out(a_bin), .tc(a_tc), .ovf(a_ovf));
    gray_counter_ud #(.DATA_WIDTH(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(s_rst), .en(s_en), .up(s_up), .load(s_ld), .load_gray(s_lg),
        .out(s_out), .bin_out(s_bin), .tc(s_tc), .ovf(s_ovf));
    gray_counter_ud #(.DATA_WIDTH(1), .WRAP(1'b1)) dut_o (
        .clk(clk), .reset(o_rst), .en(o_en), .up(o_up), .load(o_ld), .load_gray(o_lg),
        .out(o_out), .bin_out(o_bin), .tc(o_tc), .ovf(o_ovf));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic [3:0] exp_g [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        logic [3:0] mb, prev;
        logic       mo, stepped;

        a_rst = 1; a_en = 0; a_up = 0; a_ld = 0; a_lg = '0;
        s_rst = 1; s_en = 0; s_up = 0; s_ld = 0; s_lg = '0;
        o_rst = 1; o_en = 0; o_up = 0; o_ld = 0; o_lg = '0;
        tick();
        check("rst_a_out", a_out, 0); check("rst_a_bin", a_bin, 0); check("rst_a_ovf", a_ovf, 0);
        check("rst_s_out", s_out, 0); check("rst_s_ovf", s_ovf, 0);
        check("rst_o_out", o_out, 0); check("rst_o_ovf", o_ovf, 0);
        a_rst = 0; s_rst = 0; o_rst = 0;

        // Full up count through the wrap
        a_en = 1; a_up = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("up_out_%0d", i), a_out, exp_g[i]);
            check($sformatf("up_bin_%0d", i), a_bin, i % 16);
            check($sformatf("up_ovf_%0d", i), a_ovf, (i == 16));
            check($sformatf("up_tc_%0d", i), a_tc, (i == 15));
        end
        a_en = 0;
        tick();
        check("hold_ovf", a_ovf, 0); check("hold_out", a_out, 0);

        // Load Gray F then one up step
        a_ld = 1; a_lg = 4'hF;
        tick();
        check("ld_bin", a_bin, 4'hA); check("ld_out", a_out, 4'hF);
        a_ld = 0; a_en = 1; a_up = 1;
        tick();
        check("ldstep_bin", a_bin, 4'hB); check("ldstep_out", a_out, 4'hE);
        a_en = 0;

        // Down from zero wraps to MAX
        a_rst = 1;
        tick();
        a_rst = 0; a_up = 0;
        #1;
        check("dn_tc_before", a_tc, 1);
        a_en = 1;
        tick();
        check("dn_bin", a_bin, 4'hF); check("dn_out", a_out, 4'h8); check("dn_ovf", a_ovf, 1);
        a_en = 0;
        tick();
        check("dn_ovf_clear", a_ovf, 0);

        // load and en together: load wins
        a_ld = 1; a_lg = 4'h6; a_en = 1; a_up = 1;
        tick();
        check("lden_bin", a_bin, 4'h4); check("lden_out", a_out, 4'h6); check("lden_ovf", a_ovf, 0);
        // reset with load and en: reset wins
        a_rst = 1; a_lg = 4'hF;
        tick();
        check("rstld_bin", a_bin, 0); check("rstld_out", a_out, 0); check("rstld_ovf", a_ovf, 0);
        a_rst = 0; a_ld = 0;
        repeat (3) tick();
        check("mid_bin", a_bin, 3);
        a_rst = 1;
        tick();
        check("mid_rst_bin", a_bin, 0);
        a_rst = 0;
        tick();
        check("resume_bin", a_bin, 1); check("resume_out", a_out, 1);
        a_up = 0;
        tick();
        check("dir_bin", a_bin, 0); check("dir_ovf", a_ovf, 0);
        a_en = 0;

        // Saturation
        s_ld = 1; s_lg = 4'h8;
        tick();
        check("sat_ld_bin", s_bin, 4'hF); check("sat_ld_ovf", s_ovf, 0);
        s_ld = 0; s_en = 1; s_up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sat_bin_%0d", i), s_bin, 4'hF);
            check($sformatf("sat_out_%0d", i), s_out, 4'h8);
            check($sformatf("sat_ovf_%0d", i), s_ovf, 1);
            check($sformatf("sat_tc_%0d", i), s_tc, 1);
        end
        s_up = 0;
        tick();
        check("sat_dn_bin", s_bin, 4'hE); check("sat_dn_out", s_out, 4'h9); check("sat_dn_ovf", s_ovf, 0);
        s_en = 0; s_rst = 1;
        tick();
        s_rst = 0; s_en = 1;
        tick();
        check("sat0_bin", s_bin, 0); check("sat0_ovf", s_ovf, 1);
        s_en = 0;
        tick();
        check("sat0_ovf_clear", s_ovf, 0);

        // One-bit counter
        o_en = 1; o_up = 1;
        #1;
        check("w1_tc_up0", o_tc, 0);
        tick();
        check("w1_out1", o_out, 1); check("w1_bin1", o_bin, 1); check("w1_ovf1", o_ovf, 0); check("w1_tc1", o_tc, 1);
        tick();
        check("w1_out0", o_out, 0); check("w1_ovf0", o_ovf, 1); check("w1_tc0", o_tc, 0);
        o_up = 0;
        #1;
        check("w1_tc_dn0", o_tc, 1);
        tick();
        check("w1_dn_bin", o_bin, 1); check("w1_dn_ovf", o_ovf, 1);
        o_en = 0;

        // Random up/en/load against a reference model
        a_rst = 1;
        tick();
        a_rst = 0;
        mb = '0;
        for (int i = 0; i < 1000; i++) begin
            a_en = ($urandom % 4) != 0;
            a_up = $urandom % 2;
            a_ld = ($urandom % 16) == 0;
            a_lg = 4'($urandom);
            stepped = a_en && !a_ld;
            if (a_ld) begin
                mb = g2b(a_lg); mo = 0;
            end else if (a_en) begin
                if (a_up) begin mo = (mb == 4'hF); mb = mb + 4'd1; end
                else      begin mo = (mb == 4'h0); mb = mb - 4'd1; end
            end else begin
                mo = 0;
            end
            prev = a_out;
            tick();
            check("rnd_bin", a_bin, mb);
            check("rnd_ovf", a_ovf, mo);
            check("rnd_inv", a_out, a_bin ^ (a_bin >> 1));
            if (stepped) check("rnd_1bit", $countones(prev ^ a_out), 1);
        end
        a_en = 0; a_ld = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gray_counter_ud.md
# gray_counter_ud

Parametrised Gray-code counter for multi-bit values that cross clock domains, e.g. FIFO pointers and sampled timestamps. It counts up or down under an enable and can be loaded synchronously with a Gray-coded value. It either wraps or saturates at its limits. It presents registered Gray and binary views of the count, a terminal-count flag and a one-cycle overflow/saturation pulse.

## Interface
- DATA_WIDTH, default 4: counter width in bits (≥1).
- WRAP, default 1: 1 = modular wrap at the limits; 0 = saturate at the limits.

- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load; has priority over en.
- load_gray  input  DATA_WIDTH  Gray-coded value to load.
- out  output  DATA_WIDTH  registered Gray-coded count.
- bin_out  output  DATA_WIDTH  registered binary count.
- tc  output  1  terminal count for the current direction (combinational from bin_out and up).
- ovf  output  1  registered one-cycle pulse: previous step wrapped (WRAP=1) or was blocked at a limit (WRAP=0).

## Operation
- State registers: bin_r, gray_r, ovf_r. Outputs: out = gray_r, bin_out = bin_r, ovf = ovf_r.
- out is driven straight from flops, with no logic after them, so that it can be sampled safely across domains.
- Priority per rising edge: reset > load > en > hold.
- On reset: bin_r = 0, gray_r = 0, ovf_r = 0.
- On load:
  - bin_r = gray2bin(load_gray), where bin[W-1] = g[W-1] and bin[i] = bin[i+1] ^ g[i].
  - gray_r = load_gray; ovf_r = 0.
  - en and up are ignored in that cycle.
- On en with up=1:
  - If bin_r < MAX (2^DATA_WIDTH − 1): next = bin_r + 1, ovf_r = 0.
  - If bin_r == MAX with WRAP=1: next = 0, ovf_r = 1.
  - If bin_r == MAX with WRAP=0: next = MAX (hold), ovf_r = 1.
- On en with up=0:
  - If bin_r > 0: next = bin_r − 1, ovf_r = 0.
  - If bin_r == 0 with WRAP=1: next = MAX, ovf_r = 1.
  - If bin_r == 0 with WRAP=0: next = 0 (hold), ovf_r = 1.
- On every step: bin_r = next and gray_r = next ^ (next >> 1), computed from the next value rather than from bin_r, so the two registers always update together.
- With en=0 and load=0: bin_r and gray_r hold; ovf_r = 0.
- tc = up ? (bin_out == MAX) : (bin_out == 0).
- Arithmetic is DATA_WIDTH bits, unsigned. Limit detection uses compares, not carry-out.
- DATA_WIDTH = 1: Gray equals binary; gray2bin and bin2gray are identity.
- Invariant: out == bin_out ^ (bin_out >> 1) in every cycle.
- Invariant: in WRAP=1 mode with en=1, consecutive values of out differ in exactly one bit. A change of direction does not break this.

## Timing
- Latency: all registered outputs change one cycle after the edge that samples load, en or reset.
- tc follows bin_out and up in the same cycle, with no extra latency.
- ovf is high for exactly one cycle, the cycle after the boundary step.
  - Under continuous en at a WRAP=0 limit, ovf stays high for every blocked step.
- Simultaneous load and en: load wins; the count equals the loaded value and does not step.
- reset asserted together with load or en: reset wins, and all outputs read 0 on the next cycle.
- reset in the middle of a count: the count resumes from 0 on the first en after reset deasserts.
- Direction may change in any cycle. The step uses the up value sampled at that edge.

## Test plan
- Reset, then en=1, up=1 for 17 cycles (W=4, WRAP=1):
  - out follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - ovf pulses once, on the cycle out returns to 0.
  - tc is high while bin_out=F.
- Load load_gray=4'hF, then one up step:
  - After the load: bin_out=A, out=F.
  - After the step: bin_out=B, out=E.
- Down from 0, WRAP=1: after reset, one step with en=1, up=0 gives bin_out=F, out=8, ovf=1; tc was high before the step.
- WRAP=0 saturation:
  - Load 4'h8 (bin F), then three up steps: bin_out stays F and ovf is high for 3 cycles.
  - Then one down step: bin_out=E, ovf=0.
- Simultaneous events:
  - load=1 and en=1 in the same cycle: loaded value only, no step.
  - reset=1 together with load=1: outputs read 0.
  - Randomised up/en/load for 1000 cycles: the out/bin_out invariant and the single-bit-change invariant always hold.
- DATA_WIDTH=1: up count gives out 0,1,0 with ovf on the wrap; tc is correct for both directions.
